// File: rtl/fft_bitrev_reorder.sv
// Converts the bit-reversed two-lane FFT output stream into natural order
// using a ping-pong buffer: one bank is written while the other is read out.
module fft_bitrev_reorder #(
  parameter int NBITS = 21,
  parameter int N = 128,
  localparam int LOGN = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*NBITS-1:0]   reorderIn_up,
  input  logic [2*NBITS-1:0]   reorderIn_down,
  output logic [2*NBITS-1:0]   reorderOut_up,
  output logic [2*NBITS-1:0]   reorderOut_down,
  output logic                 out_valid,
  output logic                 frame_start
);

  localparam int LW = 2 * NBITS;
  localparam int AW = LOGN - 1;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [2*LW-1:0] bankMem [N];
  logic [2*LW-1:0] rdWord;
  logic [AW-1:0]   wrCnt;
  logic [AW-1:0]   rdAddr;
  logic            wrBank;
  logic            filled;
  logic [LOGN-1:0] wrIdx;
  logic [LOGN-1:0] rdIdx;

  genvar gi;
  generate
    for (gi = 0; gi < AW; gi++) begin : gRev
      assign rdAddr[gi] = wrCnt[AW-1-gi];
    end
  endgenerate

  assign wrIdx  = {wrBank, wrCnt};
  assign rdIdx  = {~wrBank, rdAddr};
  assign rdWord = bankMem[rdIdx];

  always_ff @(posedge clk) begin
    if (en) begin
      bankMem[wrIdx] <= {reorderIn_up, reorderIn_down};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reorderOut_up   <= '0;
      reorderOut_down <= '0;
      out_valid       <= 1'b0;
      frame_start     <= 1'b0;
      wrCnt           <= '0;
      wrBank          <= 1'b0;
      filled          <= 1'b0;
    end else if (!en) begin
      // Dropping en discards any partial frame; the next rise is frame 0.
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      wrCnt       <= '0;
      wrBank      <= 1'b0;
      filled      <= 1'b0;
    end else begin
      wrCnt <= wrCnt + AW'(1);
      if (&wrCnt) begin
        wrBank <= ~wrBank;
        filled <= 1'b1;
      end
      if (filled) begin
        reorderOut_up   <= rdWord[2*LW-1:LW];
        reorderOut_down <= rdWord[LW-1:0];
        out_valid       <= 1'b1;
        frame_start     <= (wrCnt == '0);
      end else begin
        out_valid   <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: a small N=8 instance for directed
// timing cases and an N=128, NBITS=21 instance for streaming and extreme data.
module tb_fft_bitrev_reorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [41:0] up;
    logic [41:0] dn;
    logic        fs;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  logic       rstA, enA, validA, fsA;
  logic [7:0] upInA, dnInA, upOutA, dnOutA;

  logic        rstB, enB, validB, fsB;
  logic [41:0] upInB, dnInB, upOutB, dnOutB;

  fft_bitrev_reorder #(.NBITS(4), .N(8)) dutA (
    .clk(clk), .rst(rstA), .en(enA),
    .reorderIn_up(upInA), .reorderIn_down(dnInA),
    .reorderOut_up(upOutA), .reorderOut_down(dnOutA),
    .out_valid(validA), .frame_start(fsA)
  );

  fft_bitrev_reorder #(.NBITS(21), .N(128)) dutB (
    .clk(clk), .rst(rstB), .en(enB),
    .reorderIn_up(upInB), .reorderIn_down(dnInB),
    .reorderOut_up(upOutB), .reorderOut_down(dnOutB),
    .out_valid(validB), .frame_start(fsB)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++)
      if (v[i]) r |= (1 << (bits - 1 - i));
    return r;
  endfunction

  // Monitors: pop one expected word for every valid output.
  always @(negedge clk) begin : monA
    exp_t e;
    if (validA === 1'b1) begin
      if (qA.size() == 0) check("A_extra_valid", 64'(validA), 64'(0));
      else begin
        e = qA.pop_front();
        check("A_up", 64'(upOutA), 64'(e.up));
        check("A_dn", 64'(dnOutA), 64'(e.dn));
        check("A_fs", 64'(fsA), 64'(e.fs));
      end
    end
  end

  always @(negedge clk) begin : monB
    exp_t e;
    if (validB === 1'b1) begin
      if (qB.size() == 0) check("B_extra_valid", 64'(validB), 64'(0));
      else begin
        e = qB.pop_front();
        check("B_up", 64'(upOutB), 64'(e.up));
        check("B_dn", 64'(dnOutB), 64'(e.dn));
        check("B_fs", 64'(fsB), 64'(e.fs));
      end
    end
  end

  // Drive nCyc cycles of a frame in bit-reversed order; push the first nPush
  // natural-order words that will be read out during the following frame.
  task automatic frameA(input logic [7:0] x[8], input int nCyc, input int nPush, input bit expValid);
    exp_t e;
    for (int t = 0; t < nPush; t++) begin
      e.up = 42'(x[t]);
      e.dn = 42'(x[t+4]);
      e.fs = (t == 0);
      qA.push_back(e);
    end
    for (int t = 0; t < nCyc; t++) begin
      int k;
      k = brev(2 * t, 3);
      enA = 1'b1;
      upInA = x[k];
      dnInA = x[k+4];
      @(posedge clk); #1;
      check("A_valid_timing", 64'(validA), 64'(expValid));
      check("A_fs_timing", 64'(fsA), 64'(expValid && t == 0));
    end
  endtask

  task automatic idleA(input int n);
    enA = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("A_valid_idle", 64'(validA), 64'(0));
    end
  endtask

  task automatic randA(output logic [7:0] x[8]);
    for (int k = 0; k < 8; k++) x[k] = 8'($urandom);
  endtask

  // nFrames output frames; one extra input frame drives the last readout.
  task automatic streamB(input int nFrames, input int mode);
    logic [41:0] x[128];
    logic [20:0] re;
    exp_t e;
    for (int f = 0; f <= nFrames; f++) begin
      for (int k = 0; k < 128; k++) begin
        if (mode == 0) x[k] = {21'($urandom), 21'($urandom)};
        else begin
          re = ((k % 2) == 1) ? 21'h100000 : 21'h0FFFFF;
          if (k >= 64) re = re ^ 21'h1FFFFF;
          x[k] = {re, re ^ 21'h1FFFFF};
        end
      end
      if (f < nFrames)
        for (int t = 0; t < 64; t++) begin
          e.up = x[t];
          e.dn = x[t+64];
          e.fs = (t == 0);
          qB.push_back(e);
        end
      for (int t = 0; t < 64; t++) begin
        int k;
        k = brev(2 * t, 7);
        enB = 1'b1;
        upInB = x[k];
        dnInB = x[k+64];
        @(posedge clk); #1;
        check("B_valid_timing", 64'(validB), 64'(f > 0));
        check("B_fs_timing", 64'(fsB), 64'(f > 0 && t == 0));
      end
    end
    enB = 1'b0;
    @(posedge clk); #1;
    check("B_valid_idle", 64'(validB), 64'(0));
  endtask

  initial begin
    logic [7:0] xa[8];
    logic [7:0] x0[8], x1[8], x2[8], x3[8], x4[8], x5[8];

    rstA = 1'b1; enA = 1'b0; upInA = '0; dnInA = '0;
    rstB = 1'b1; enB = 1'b0; upInB = '0; dnInB = '0;
    #7;
    check("A_rst_valid", 64'(validA), 64'(0));
    check("A_rst_fs", 64'(fsA), 64'(0));
    check("A_rst_up", 64'(upOutA), 64'(0));
    check("A_rst_dn", 64'(dnOutA), 64'(0));
    check("B_rst_valid", 64'(validB), 64'(0));
    check("B_rst_up", 64'(upOutB), 64'(0));
    rstA = 1'b0; rstB = 1'b0;
    @(posedge clk); #1;

    // Directed N=8: X[k]=k in re, 15-k in im; frames repeat identically.
    for (int k = 0; k < 8; k++) xa[k] = {4'(k), 4'(15 - k)};
    frameA(xa, 4, 4, 1'b0);
    frameA(xa, 4, 4, 1'b1);
    frameA(xa, 4, 0, 1'b1);
    idleA(2);

    // en drops at edge 6, returns at edge 9; first new output at edge 13.
    randA(x0); randA(x1); randA(x2); randA(x3);
    frameA(x0, 4, 2, 1'b0);
    frameA(x1, 2, 0, 1'b1);
    idleA(3);
    frameA(x2, 4, 4, 1'b0);
    frameA(x3, 4, 0, 1'b1);
    idleA(1);

    // Asynchronous reset partway through frame 3, en held high.
    randA(x0); randA(x1); randA(x2); randA(x3); randA(x4); randA(x5);
    frameA(x0, 4, 4, 1'b0);
    frameA(x1, 4, 4, 1'b1);
    frameA(x2, 4, 4, 1'b1);
    frameA(x3, 2, 0, 1'b1);
    #1 rstA = 1'b1;
    #1;
    check("A_arst_valid", 64'(validA), 64'(0));
    check("A_arst_fs", 64'(fsA), 64'(0));
    check("A_arst_up", 64'(upOutA), 64'(0));
    check("A_arst_dn", 64'(dnOutA), 64'(0));
    qA.delete();
    #1 rstA = 1'b0;
    frameA(x4, 4, 4, 1'b0);
    frameA(x5, 4, 0, 1'b1);
    idleA(1);

    // N=128: ten random back-to-back frames, then extreme re/im patterns.
    streamB(10, 0);
    streamB(2, 1);

    @(posedge clk); #1;
    check("A_queue_empty", 64'(qA.size()), 64'(0));
    check("B_queue_empty", 64'(qB.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
